// File: rtl/pp_pkg.sv
// pp_pkg: shared state encoding and default target pattern for pattern_detector.
package pp_pkg;
    typedef enum logic {FILL = 1'b0, ARMED = 1'b1} pd_state_t;
    localparam logic [5:0] DEFAULT_PATTERN = 6'b10_01_00;
endpackage

// File: rtl/pp_sym_shift.sv
// pp_sym_shift: DEPTH-symbol history shift register with saturating fill counter.
module pp_sym_shift #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 3,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic                   restart,
    input  logic [SYM_W-1:0]       sym,
    output logic [DEPTH*SYM_W-1:0] hist_next,
    output logic [FW-1:0]          fill
);
    localparam int HW = DEPTH * SYM_W;

    logic [HW-1:0] hist;

    // the cast drops the oldest symbol off the MSB end
    assign hist_next = HW'({hist, sym});

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_next;
            fill <= restart ? '0 : (fill == FW'(DEPTH) ? fill : fill + 1'b1);
        end
    end
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: matches a DEPTH-symbol sequence, emits a one-cycle pulse and counts matches.
module pattern_detector
    import pp_pkg::*;
#(
    parameter int                     SYM_W   = 2,
    parameter int                     DEPTH   = 3,
    parameter logic [DEPTH*SYM_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit                     OVERLAP = 1'b1,
    parameter int                     CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    input  logic             clear,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH*SYM_W-1:0] hist_next;
    logic [FW-1:0]          fill;
    logic                   match;
    logic                   restart;
    logic                   near_full;
    pd_state_t              state;
    pd_state_t              state_nx;

    pp_sym_shift #(.SYM_W(SYM_W), .DEPTH(DEPTH), .FW(FW)) u_shift (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (clear),
        .shift    (sym_valid),
        .restart  (restart),
        .sym      (sym_in),
        .hist_next(hist_next),
        .fill     (fill)
    );

    assign near_full = fill >= FW'(DEPTH - 1);
    assign match     = sym_valid && !clear && near_full && hist_next == PATTERN;
    assign restart   = match && !OVERLAP;
    assign armed     = state == ARMED;

    always_comb begin
        state_nx = state;
        state_nx = (clear || restart) ? FILL : (sym_valid && near_full) ? ARMED : state;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= FILL;
            q         <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_nx;
            q         <= match;
            match_cnt <= clear ? '0 : (match && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
        end
    end
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed vectors with a queued scoreboard over four parameter variants.
module tb_pattern_detector;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       sym_valid = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] sym_in = 2'b00;

    logic       q0, q1, q2, q3;
    logic       a0, a1, a2, a3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    typedef struct {
        int    id;
        logic  q;
        int    cnt;
        logic  armed;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errs = 0;

    always #5 Clk = ~Clk;

    pattern_detector u0 (
        .Clk(Clk), .Rst(Rst), .sym_in(sym_in), .sym_valid(sym_valid), .clear(clear),
        .q(q0), .match_cnt(c0), .armed(a0)
    );
    pattern_detector #(.PATTERN(6'b10_10_10), .OVERLAP(1'b1)) u1 (
        .Clk(Clk), .Rst(Rst), .sym_in(sym_in), .sym_valid(sym_valid), .clear(clear),
        .q(q1), .match_cnt(c1), .armed(a1)
    );
    pattern_detector #(.PATTERN(6'b10_10_10), .OVERLAP(1'b0)) u2 (
        .Clk(Clk), .Rst(Rst), .sym_in(sym_in), .sym_valid(sym_valid), .clear(clear),
        .q(q2), .match_cnt(c2), .armed(a2)
    );
    pattern_detector #(.CNT_W(2)) u3 (
        .Clk(Clk), .Rst(Rst), .sym_in(sym_in), .sym_valid(sym_valid), .clear(clear),
        .q(q3), .match_cnt(c3), .armed(a3)
    );

    function automatic logic [31:0] q_of(int id);
        return id == 0 ? {31'd0, q0} : id == 1 ? {31'd0, q1} : id == 2 ? {31'd0, q2} : {31'd0, q3};
    endfunction

    function automatic logic [31:0] a_of(int id);
        return id == 0 ? {31'd0, a0} : id == 1 ? {31'd0, a1} : id == 2 ? {31'd0, a2} : {31'd0, a3};
    endfunction

    function automatic logic [31:0] c_of(int id);
        return id == 0 ? {24'd0, c0} : id == 1 ? {24'd0, c1} : id == 2 ? {24'd0, c2} : {30'd0, c3};
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int id, logic eq, int ec, logic ea);
        chk({tag, ".q"}, q_of(id), {31'd0, eq});
        chk({tag, ".cnt"}, c_of(id), ec);
        chk({tag, ".armed"}, a_of(id), {31'd0, ea});
    endtask

    // results of the edge that follows each queued step
    always @(posedge Clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk_all(mon_e.tag, mon_e.id, mon_e.q, mon_e.cnt, mon_e.armed);
        end
    end

    task automatic step(int id, logic v, logic [1:0] s, logic c, logic eq, int ec, logic ea, string tag);
        exp_t e;
        @(negedge Clk);
        sym_valid = v;
        sym_in    = s;
        clear     = c;
        e.id = id; e.q = eq; e.cnt = ec; e.armed = ea; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge Clk);
            #3;
            n++;
        end
        if (sb.size() > 0) chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset;
        drain();
        @(negedge Clk);
        Rst = 1'b0; sym_valid = 1'b0; clear = 1'b0; sym_in = 2'b00;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        for (int i = 0; i < 4; i++) chk_all("por", i, 1'b0, 0, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;

        step(0, 1, 2'b10, 0, 0, 0, 0, "t1.e1");
        step(0, 1, 2'b01, 0, 0, 0, 0, "t1.e2");
        step(0, 1, 2'b00, 0, 1, 1, 1, "t1.e3");
        step(0, 0, 2'b00, 0, 0, 1, 1, "t1.idle");
        step(0, 0, 2'b00, 1, 0, 0, 0, "t1.clr");
        step(0, 0, 2'b00, 0, 0, 0, 0, "t1.post");

        do_reset();
        step(0, 1, 2'b10, 0, 0, 0, 0, "t2.s10");
        step(0, 0, 2'b00, 0, 0, 0, 0, "t2.i1");
        step(0, 0, 2'b11, 0, 0, 0, 0, "t2.i2");
        step(0, 1, 2'b01, 0, 0, 0, 0, "t2.s01");
        step(0, 0, 2'b10, 0, 0, 0, 0, "t2.i3");
        step(0, 1, 2'b00, 0, 1, 1, 1, "t2.s00");
        step(0, 0, 2'b00, 0, 0, 1, 1, "t2.idle");

        do_reset();
        step(0, 1, 2'b10, 0, 0, 0, 0, "t3.e1");
        step(0, 1, 2'b11, 0, 0, 0, 0, "t3.e2");
        step(0, 1, 2'b01, 0, 0, 0, 1, "t3.e3");
        step(0, 1, 2'b00, 0, 0, 0, 1, "t3.e4");
        step(0, 0, 2'b00, 0, 0, 0, 1, "t3.idle");

        do_reset();
        step(1, 1, 2'b10, 0, 0, 0, 0, "t4.e1");
        step(1, 1, 2'b10, 0, 0, 0, 0, "t4.e2");
        step(1, 1, 2'b10, 0, 1, 1, 1, "t4.e3");
        step(1, 1, 2'b10, 0, 1, 2, 1, "t4.e4");
        step(1, 0, 2'b10, 0, 0, 2, 1, "t4.idle");

        do_reset();
        step(2, 1, 2'b10, 0, 0, 0, 0, "t5.e1");
        step(2, 1, 2'b10, 0, 0, 0, 0, "t5.e2");
        step(2, 1, 2'b10, 0, 1, 1, 0, "t5.e3");
        step(2, 1, 2'b10, 0, 0, 1, 0, "t5.e4");
        step(2, 0, 2'b10, 0, 0, 1, 0, "t5.idle");

        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(3, 1, 2'b10, 0, 0, k < 3 ? k : 3, k > 0, "t6.s10");
            step(3, 1, 2'b01, 0, 0, k < 3 ? k : 3, k > 0, "t6.s01");
            step(3, 1, 2'b00, 0, 1, k + 1 < 3 ? k + 1 : 3, 1, "t6.s00");
            step(3, 0, 2'b00, 0, 0, k + 1 < 3 ? k + 1 : 3, 1, "t6.idle");
        end

        do_reset();
        step(0, 1, 2'b10, 0, 0, 0, 0, "t7.e1");
        step(0, 1, 2'b01, 0, 0, 0, 0, "t7.e2");
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        sym_valid = 1'b0;
        #1;
        chk_all("t7.midrst", 0, 1'b0, 0, 1'b0);
        #3;
        Rst = 1'b1;
        #1;
        chk_all("t7.release", 0, 1'b0, 0, 1'b0);
        step(0, 1, 2'b00, 0, 0, 0, 0, "t7.s00");
        step(0, 1, 2'b10, 0, 0, 0, 0, "t7.s10");
        step(0, 1, 2'b01, 0, 0, 0, 1, "t7.s01");
        step(0, 1, 2'b00, 0, 1, 1, 1, "t7.match");
        step(0, 0, 2'b00, 0, 0, 1, 1, "t7.idle");

        do_reset();
        step(0, 1, 2'b10, 0, 0, 0, 0, "t8.e1");
        step(0, 1, 2'b01, 0, 0, 0, 0, "t8.e2");
        step(0, 1, 2'b00, 1, 0, 0, 0, "t8.clr");
        step(0, 0, 2'b00, 0, 0, 0, 0, "t8.idle");
        step(0, 1, 2'b00, 0, 0, 0, 0, "t8.s00");
        step(0, 0, 2'b00, 0, 0, 0, 0, "t8.end");

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2, meaning symbol width in bits; bit order {x,y}.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning pattern length in symbols, legal range 2..16.
REQ-003 The block SHALL have parameter PATTERN, default 6'b10_01_00, meaning DEPTH*SYM_W-bit target sequence with the oldest symbol in the MSBs.
REQ-004 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = history restarts after each match.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-006 Port Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port Rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 Port sym_in  in  SYM_W  SHALL carry the input symbol.
REQ-009 Port sym_valid  in  1  SHALL qualify sym_in; a symbol is accepted only on an edge where sym_valid=1.
REQ-010 Port clear  in  1  SHALL be a synchronous clear of history, fill count, q and counter.
REQ-011 Port q  out  1  SHALL be the registered one-cycle match pulse.
REQ-012 Port match_cnt  out  CNT_W  SHALL be the saturating count of matches.
REQ-013 Port armed  out  1  SHALL be high when DEPTH symbols are held since reset, clear or a non-overlap restart.

Function
REQ-014 The history SHALL be a DEPTH-entry shift register; an accepted symbol enters at the LSB end and the oldest symbol is discarded.
REQ-015 The fill count SHALL increment per accepted symbol, saturating at DEPTH; armed = (fill == DEPTH).
REQ-016 State machine: FILL (fill < DEPTH) -> ARMED when fill reaches DEPTH; ARMED -> FILL on clear, or on a match when OVERLAP=0.
REQ-017 Match condition SHALL be: symbol accepted AND fill >= DEPTH-1 before the edge AND the shifted history equals PATTERN.
REQ-018 q SHALL rise on the same edge that accepts the completing symbol (1-cycle latency from input) and SHALL be high for exactly one cycle per match.
REQ-019 Back-to-back matches (OVERLAP=1) SHALL produce q high on consecutive cycles with no forced gap.
REQ-020 With OVERLAP=0, a match SHALL set fill to 0, so the next match needs DEPTH new symbols.
REQ-021 Cycles with sym_valid=0 SHALL hold the history, fill, armed and match_cnt, and SHALL drive q=0.
REQ-022 match_cnt SHALL increment on the q edge and saturate at 2^CNT_W-1 (no wrap).
REQ-023 clear SHALL have priority over sym_valid; on the edge where clear=1, the block SHALL clear history, fill, q and match_cnt to 0, and the symbol on that edge SHALL be discarded.

Reset
REQ-024 Rst=0 SHALL immediately force history=0, fill=0, state FILL, q=0, match_cnt=0, armed=0, independent of Clk.
REQ-025 The first symbol SHALL be accepted on the first rising edge after Rst deasserts at which sym_valid=1.
REQ-026 A partial sequence in progress when reset asserts SHALL be discarded entirely.

Structure
REQ-027 Shared package pp_pkg SHALL hold the FILL/ARMED state encoding and the default pattern constant.
REQ-028 One sub-module, pp_sym_shift (parametrised SYM_W x DEPTH history register with fill counter), SHALL be instantiated.
REQ-029 Compare, FSM and counter SHALL reside in pattern_detector; the implementation SHALL be synthesizable with no latches.

Verification
REQ-030 Defaults, after reset: symbols 10,01,00 with sym_valid=1 on three consecutive edges -> q=1 for one cycle after the third edge, match_cnt=1.
REQ-031 Defaults: 10, idle 2 cycles, 01, idle, 00 -> single match; stream 10,11,01,00 -> no match, match_cnt=0.
REQ-032 PATTERN=6'b10_10_10, stream 10 x4: OVERLAP=1 -> q high after edges 3 and 4, match_cnt=2; OVERLAP=0 -> q after edge 3 only, match_cnt=1, armed=0 after edge 3.
REQ-033 CNT_W=2, five separated matches -> match_cnt sequence 1,2,3,3,3.
REQ-034 Defaults: 10,01 accepted, Rst pulsed low mid-cycle -> outputs 0 before the next edge; after release, 00 alone -> no match; full 10,01,00 -> match.
REQ-035 Defaults: clear=1 and sym_valid=1 with sym_in=00 on the edge completing 10,01,00 -> q=0, match_cnt=0, armed=0.
